gshare_multi_predictor: RTL and testbench
=========================================

// Module: gshare_multi_predictor
// PURPOSE
//  Parametrised gshare direction predictor for an N-wide fetch front end.
//  Predicts every fetch slot in one cycle from a shared PHT and per-slot GHR snapshot.
//  Speculatively updates the GHR at fetch and trains the PHT from EXE.
//  Adds: configurable counter width and hash mode, a PHT init sweep FSM, and a misprediction counter.
//  Sits between the BTB/fetch stage and EXE.
// PARAMETERS
//  FETCH_WIDTH    2   slots predicted per cycle (>=1, <=GHR_WIDTH)
//  GHR_WIDTH      8   global history bits (>=2)
//  PHT_IDX_WIDTH  8   PHT index bits; PHT_SIZE = 2**PHT_IDX_WIDTH
//  CTR_BITS       2   saturating counter width (>=2)
//  HASH_MODE      0   0 = XOR of pc and GHR; 1 = concat of GHR and pc
// PORTS
//  clk            in   1                  clock, rising edge
//  reset          in   1                  synchronous, active-high
//  if_valid       in   FETCH_WIDTH        slot k holds a valid fetched instr
//  if_hit         in   FETCH_WIDTH        slot k hit a conditional-branch BTB entry
//  if_pc          in   32*FETCH_WIDTH     slot k pc = if_pc[32k+:32]
//  pred_taken     out  FETCH_WIDTH        slot k predicted taken
//  pred_ghr       out  GHR_WIDTH*FETCH_WIDTH  GHR checkpoint used by slot k; travels with the instr
//  ready          out  1                  init sweep done, predictor active
//  ex_valid       in   1                  EXE reports a resolved control-flow instr
//  ex_is_cond     in   1                  resolved instr is a conditional branch
//  ex_taken       in   1                  actual direction
//  ex_mispredict  in   1                  direction or BTB miss -> GHR restore
//  ex_pc          in   32                 pc of resolved instr
//  ex_ghr         in   GHR_WIDTH          checkpoint carried from fetch (pred_ghr)
//  mispredict_cnt out  32                 count of ex_valid&ex_mispredict, saturates at all-ones
// BEHAVIOUR
//  Reset
//   - state = INIT, init_ptr = 0, GHR = 0, mispredict_cnt = 0.
//   - ready = 0, pred_taken = 0.
//   - Reset asserted mid-INIT or mid-RUN restarts the sweep from index 0.
//  FSM INIT
//   - Each cycle writes PHT[init_ptr] = 2**(CTR_BITS-1) (weakly taken), then init_ptr++.
//   - After the write to PHT_SIZE-1, go to RUN.
//   - ready rises exactly PHT_SIZE cycles after reset deasserts.
//   - In INIT: pred_taken = 0, GHR frozen, ex_* inputs ignored (mispredict_cnt still counts).
//  FSM RUN
//   - Stays in RUN until reset.
//  Hash (pc bits p = pc[PHT_IDX_WIDTH+1:2])
//   - Mode 0: idx = p ^ GHR, GHR zero-extended or truncated (low bits kept) to PHT_IDX_WIDTH.
//   - Mode 1: H = PHT_IDX_WIDTH/2; idx = {GHR[H-1:0], pc[PHT_IDX_WIDTH-H+1:2]}.
//  Prediction (combinational, RUN only)
//   - pred_ghr[0] = GHR.
//   - pred_ghr[k] = pred_ghr[k-1] shifted left with 0 in, if slot k-1 is valid&hit&!pred_taken; else unchanged.
//   - pred_taken[k] = valid&hit & MSB(PHT[hash(pred_ghr[k], pc_k)]).
//   - Slots after the first predicted-taken slot are forced to pred_taken = 0 (squashed).
//  Speculative GHR (RUN, no restore this cycle)
//   - Shift in one bit per valid&hit slot, in slot order, up to and including the first predicted-taken slot.
//   - Bit shifted in = that slot's prediction.
//   - No hit slots -> GHR unchanged.
//  Restore (RUN, ex_valid&ex_mispredict; wins over speculative update)
//   - Conditional: GHR <= {ex_ghr[GHR_WIDTH-2:0], ex_taken}.
//   - Not conditional: GHR <= ex_ghr.
//  Training (RUN, ex_valid&ex_is_cond)
//   - Entry e = hash(ex_ghr, ex_pc).
//   - e saturating +1 if ex_taken, -1 otherwise; clamps at 0 and 2**CTR_BITS-1.
//   - Written at the clock edge.
//   - A same-cycle fetch read of e sees the old value (no bypass).
//   - Back-to-back updates to e both take effect.
// TESTING
//  1. Reset 1 cycle, PHT_IDX_WIDTH=8 -> ready=0 for 256 cycles, then 1.
//     All entries = 2'b10; any hit slot predicts taken.
//  2. FETCH_WIDTH=2, GHR=0, slot0 hit with ctr=01, slot1 hit with ctr=10
//     -> pred_taken=2'b10, pred_ghr[1]=GHR<<1, next GHR=8'b0000_0001.
//  3. Both slots hit, slot0 predicts taken
//     -> pred_taken=2'b01, GHR shifts one bit in (1).
//  4. Same-cycle spec update and ex mispredict, cond, ex_ghr=8'hA5, ex_taken=0
//     -> GHR=8'h4A; mispredict_cnt +1.
//  5. Three ex_taken=0 updates to one entry from 2'b10 -> 01, 00, 00 (saturates).
//     CTR_BITS=3 from 3'b100 with 4 taken -> 3'b111.
//  6. HASH_MODE=1 -> index per concat rule.
//     Reset mid-RUN -> ready=0, GHR=0, sweep restarts at index 0.

Source files
------------

// File: rtl/gshare_multi_predictor.sv
// Gshare direction predictor for an N-wide fetch front end.
// The PHT is shared by all slots and is trained from EXE. The GHR is updated speculatively at fetch and restored on a mispredict.
module gshare_multi_predictor #(
  parameter int FETCH_WIDTH   = 2,
  parameter int GHR_WIDTH     = 8,
  parameter int PHT_IDX_WIDTH = 8,
  parameter int CTR_BITS      = 2,
  parameter int HASH_MODE     = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [FETCH_WIDTH-1:0]           if_valid,
  input  logic [FETCH_WIDTH-1:0]           if_hit,
  input  logic [32*FETCH_WIDTH-1:0]        if_pc,
  output logic [FETCH_WIDTH-1:0]           pred_taken,
  output logic [GHR_WIDTH*FETCH_WIDTH-1:0] pred_ghr,
  output logic                             ready,
  input  logic                             ex_valid,
  input  logic                             ex_is_cond,
  input  logic                             ex_taken,
  input  logic                             ex_mispredict,
  input  logic [31:0]                      ex_pc,
  input  logic [GHR_WIDTH-1:0]             ex_ghr,
  output logic [31:0]                      mispredict_cnt
);

  localparam int PHT_SIZE = 1 << PHT_IDX_WIDTH;
  localparam int HALF_IDX = PHT_IDX_WIDTH / 2;
  localparam logic [CTR_BITS-1:0] CTR_WEAK = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

  // ready is simply (state_q == ST_RUN), so it exposes the FSM state to checkers.
  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                   state_q, state_d;
  logic [PHT_IDX_WIDTH-1:0] init_ptr_q, init_ptr_d;
  logic [GHR_WIDTH-1:0]     ghr_q, ghr_d;
  logic [31:0]              mispredict_cnt_q, mispredict_cnt_d;
  logic [CTR_BITS-1:0]      pht_q [PHT_SIZE];

  logic                     pht_we;
  logic [PHT_IDX_WIDTH-1:0] pht_widx;
  logic [CTR_BITS-1:0]      pht_wdata;
  logic [GHR_WIDTH-1:0]     spec_ghr;
  logic [PHT_IDX_WIDTH-1:0] ex_idx;
  logic [CTR_BITS-1:0]      ex_ctr;
  logic                     unused_pc_bits;

  function automatic logic [PHT_IDX_WIDTH-1:0] pht_hash(
    input logic [GHR_WIDTH-1:0] g,
    input logic [31:0]          pc
  );
    logic [GHR_WIDTH+PHT_IDX_WIDTH-1:0] g_ext;
    logic [PHT_IDX_WIDTH-1:0]           idx;
    g_ext = {{PHT_IDX_WIDTH{1'b0}}, g};
    if (HASH_MODE == 0) begin
      idx = pc[PHT_IDX_WIDTH+1:2] ^ g_ext[PHT_IDX_WIDTH-1:0];
    end else begin
      idx = {g_ext[HALF_IDX-1:0], pc[PHT_IDX_WIDTH-HALF_IDX+1:2]};
    end
    return idx;
  endfunction

  assign unused_pc_bits = ^{if_pc, ex_pc};
  assign ex_idx         = pht_hash(ex_ghr, ex_pc);
  assign ex_ctr         = pht_q[ex_idx];
  assign ready          = (state_q == ST_RUN);
  assign mispredict_cnt = mispredict_cnt_q;

  // Each slot sees the history as it stands after the older slots' not-taken shifts.
  // Everything after the first taken slot is squashed.
  always_comb begin
    logic [GHR_WIDTH-1:0]     g;
    logic [PHT_IDX_WIDTH-1:0] slot_idx;
    logic                     taken_seen;
    logic                     hv;
    logic                     pt;
    g          = ghr_q;
    slot_idx   = '0;
    taken_seen = 1'b0;
    hv         = 1'b0;
    pt         = 1'b0;
    pred_taken = '0;
    pred_ghr   = '0;
    spec_ghr   = ghr_q;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      hv = if_valid[k] & if_hit[k];
      pred_ghr[k*GHR_WIDTH +: GHR_WIDTH] = g;
      slot_idx = pht_hash(g, if_pc[32*k +: 32]);
      pt = (state_q == ST_RUN) & hv & ~taken_seen & pht_q[slot_idx][CTR_BITS-1];
      pred_taken[k] = pt;
      if (hv & ~taken_seen) begin
        spec_ghr = {spec_ghr[GHR_WIDTH-2:0], pt};
      end
      if (hv & ~pt) begin
        g = {g[GHR_WIDTH-2:0], 1'b0};
      end
      if (pt) begin
        taken_seen = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    init_ptr_d       = init_ptr_q;
    ghr_d            = ghr_q;
    mispredict_cnt_d = mispredict_cnt_q;
    pht_we           = 1'b0;
    pht_widx         = '0;
    pht_wdata        = '0;

    if (ex_valid & ex_mispredict & ~(&mispredict_cnt_q)) begin
      mispredict_cnt_d = mispredict_cnt_q + 32'd1;
    end

    case (state_q)
      ST_INIT: begin
        pht_we     = 1'b1;
        pht_widx   = init_ptr_q;
        pht_wdata  = CTR_WEAK;
        init_ptr_d = init_ptr_q + 1'b1;
        if (&init_ptr_q) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // A restore from EXE overrides this cycle's speculative shifts.
        if (ex_valid & ex_mispredict) begin
          ghr_d = ex_is_cond ? {ex_ghr[GHR_WIDTH-2:0], ex_taken} : ex_ghr;
        end else begin
          ghr_d = spec_ghr;
        end
        if (ex_valid & ex_is_cond) begin
          pht_we   = 1'b1;
          pht_widx = ex_idx;
          if (ex_taken) begin
            pht_wdata = (ex_ctr == CTR_MAX) ? ex_ctr : ex_ctr + 1'b1;
          end else begin
            pht_wdata = (ex_ctr == '0) ? ex_ctr : ex_ctr - 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_INIT;
      init_ptr_q       <= '0;
      ghr_q            <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      state_q          <= state_d;
      init_ptr_q       <= init_ptr_d;
      ghr_q            <= ghr_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  // The PHT has no reset: the init sweep is what establishes its contents.
  always_ff @(posedge clk) begin
    if (pht_we & ~reset) begin
      pht_q[pht_widx] <= pht_wdata;
    end
  end

endmodule

// File: tb/tb_gshare_multi_predictor.sv
// Bench for gshare_multi_predictor. Two instances share the stimulus: one uses XOR hashing with 2-bit counters, the other concat hashing with 3-bit counters.
module tb_gshare_multi_predictor;

  localparam int NPHT = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  if_valid, if_hit;
  logic [63:0] if_pc;
  logic        ex_valid, ex_is_cond, ex_taken, ex_mispredict;
  logic [31:0] ex_pc;
  logic [7:0]  ex_ghr;

  logic [1:0]  pt  [2];
  logic [15:0] pg  [2];
  logic        rdy [2];
  logic [31:0] cnt [2];

  int checks = 0;
  int errors = 0;

  int          m_pht [2][NPHT];
  logic [7:0]  m_ghr [2];
  logic [31:0] m_cnt;
  int          m_cycles;
  bit          m_valid = 1'b0;
  int          cbits [2] = '{2, 3};
  int          hmode [2] = '{0, 1};

  always #5 clk = ~clk;

  gshare_multi_predictor #(
    .FETCH_WIDTH(2), .GHR_WIDTH(8), .PHT_IDX_WIDTH(8), .CTR_BITS(2), .HASH_MODE(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_hit(if_hit), .if_pc(if_pc),
    .pred_taken(pt[0]), .pred_ghr(pg[0]), .ready(rdy[0]),
    .ex_valid(ex_valid), .ex_is_cond(ex_is_cond), .ex_taken(ex_taken),
    .ex_mispredict(ex_mispredict), .ex_pc(ex_pc), .ex_ghr(ex_ghr),
    .mispredict_cnt(cnt[0])
  );

  gshare_multi_predictor #(
    .FETCH_WIDTH(2), .GHR_WIDTH(8), .PHT_IDX_WIDTH(8), .CTR_BITS(3), .HASH_MODE(1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_hit(if_hit), .if_pc(if_pc),
    .pred_taken(pt[1]), .pred_ghr(pg[1]), .ready(rdy[1]),
    .ex_valid(ex_valid), .ex_is_cond(ex_is_cond), .ex_taken(ex_taken),
    .ex_mispredict(ex_mispredict), .ex_pc(ex_pc), .ex_ghr(ex_ghr),
    .mispredict_cnt(cnt[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int hidx(input int mode, input logic [7:0] g, input logic [31:0] pc);
    if (mode == 0) return int'(pc[9:2] ^ g);
    return int'({g[3:0], pc[5:2]});
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int e = 0; e < NPHT; e++) m_pht[i][e] = 1 << (cbits[i] - 1);
      m_ghr[i] = 8'h00;
    end
    m_cnt    = 32'd0;
    m_cycles = 0;
  endtask

  // Reference model: outputs follow from the current model state and inputs; the state then advances one cycle.
  logic [7:0]  c_g, c_sg;
  logic [1:0]  c_pt;
  logic [15:0] c_pg;
  bit          c_run, c_tk, c_hv, c_p;
  int          c_e, c_half, c_max;

  always @(negedge clk) begin
    if (reset) begin
      model_reset();
      m_valid = 1'b1;
    end else if (m_valid) begin
      c_run = (m_cycles >= NPHT);
      for (int i = 0; i < 2; i++) begin
        c_half = 1 << (cbits[i] - 1);
        c_max  = (1 << cbits[i]) - 1;
        c_g = m_ghr[i]; c_sg = m_ghr[i]; c_tk = 1'b0; c_pt = '0; c_pg = '0;
        for (int k = 0; k < 2; k++) begin
          c_hv = if_valid[k] && if_hit[k];
          c_pg[8*k +: 8] = c_g;
          c_e = hidx(hmode[i], c_g, if_pc[32*k +: 32]);
          c_p = c_run && c_hv && !c_tk && (m_pht[i][c_e] >= c_half);
          c_pt[k] = c_p;
          if (c_hv && !c_tk) c_sg = 8'((c_sg * 2) + c_p);
          if (c_hv && !c_p) c_g = 8'(c_g * 2);
          if (c_p) c_tk = 1'b1;
        end
        chk($sformatf("ready%0d", i), 64'(rdy[i]), 64'(c_run));
        chk($sformatf("pred_taken%0d", i), 64'(pt[i]), 64'(c_pt));
        chk($sformatf("mispredict_cnt%0d", i), 64'(cnt[i]), 64'(m_cnt));
        if (c_run) chk($sformatf("pred_ghr%0d", i), 64'(pg[i]), 64'(c_pg));
        if (c_run) begin
          if (ex_valid && ex_mispredict)
            m_ghr[i] = ex_is_cond ? 8'((ex_ghr * 2) + ex_taken) : ex_ghr;
          else
            m_ghr[i] = c_sg;
          if (ex_valid && ex_is_cond) begin
            c_e = hidx(hmode[i], ex_ghr, ex_pc);
            if (ex_taken) m_pht[i][c_e] = (m_pht[i][c_e] + 1 > c_max) ? c_max : m_pht[i][c_e] + 1;
            else          m_pht[i][c_e] = (m_pht[i][c_e] - 1 < 0) ? 0 : m_pht[i][c_e] - 1;
          end
        end
      end
      if (ex_valid && ex_mispredict && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (m_cycles < NPHT) m_cycles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    if_valid = '0; if_hit = '0; if_pc = '0;
    ex_valid = 1'b0; ex_is_cond = 1'b0; ex_taken = 1'b0; ex_mispredict = 1'b0;
    ex_pc = '0; ex_ghr = '0;
  endtask

  task automatic rand_drive();
    if_valid      = 2'($urandom_range(0, 3));
    if_hit        = 2'($urandom_range(0, 3));
    if_pc[31:0]   = 32'h1000 + 32'(4 * $urandom_range(0, 31));
    if_pc[63:32]  = 32'h1000 + 32'(4 * $urandom_range(0, 31));
    ex_valid      = 1'($urandom_range(0, 1));
    ex_is_cond    = ($urandom_range(0, 3) != 0);
    ex_taken      = 1'($urandom_range(0, 1));
    ex_mispredict = ($urandom_range(0, 3) == 0);
    ex_pc         = 32'h1000 + 32'(4 * $urandom_range(0, 31));
    ex_ghr        = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
  endtask

  // Called right after reset drops; n counts the clock edges until ready is seen.
  task automatic wait_ready(input string tag, input bit do_rand);
    int n;
    n = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_ready_low"}, 64'(rdy[i]), 64'd0);
      chk({tag, "_ghr_zero"}, 64'(pg[i][7:0]), 64'd0);
      chk({tag, "_cnt_zero"}, 64'(cnt[i]), 64'd0);
    end
    while (rdy[0] !== 1'b1 && n < 400) begin
      n++;
      tick();
      if (do_rand) rand_drive();
      @(negedge clk);
    end
    chk({tag, "_sweep_cycles"}, 64'(n), 64'd256);
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    tick();
    tick();
    reset = 1'b0;
    wait_ready("t1_sweep", 1'b0);

    // All entries weakly taken: slot0 predicts taken and slot1 is squashed; a non-cond restore keeps GHR at 0.
    tick(); clr_in();
    if_valid = 2'b11; if_hit = 2'b11; if_pc = {32'h300, 32'h200};
    ex_valid = 1'b1; ex_mispredict = 1'b1; ex_ghr = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("t1_weak_taken", 64'(pt[i]), 64'h1);
      chk("t1_pred_ghr", 64'(pg[i]), 64'h0000);
    end

    tick(); clr_in();
    ex_valid = 1'b1; ex_is_cond = 1'b1; ex_taken = 1'b0; ex_pc = 32'h100; ex_ghr = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("t1_restore_ghr", 64'(pg[i][7:0]), 64'h00);
      chk("t1_cnt_one", 64'(cnt[i]), 64'd1);
    end

    // Slot0 counter is weakly not-taken and slot1 counter is weakly taken.
    tick(); clr_in();
    if_valid = 2'b11; if_hit = 2'b11; if_pc = {32'h104, 32'h100};
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("t2_pred_taken", 64'(pt[i]), 64'h2);
      chk("t2_pred_ghr", 64'(pg[i]), 64'h0000);
    end

    tick(); clr_in();
    if_valid = 2'b11; if_hit = 2'b11; if_pc = {32'h204, 32'h200};
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("t2_next_ghr", 64'(pg[i][7:0]), 64'h01);
      chk("t3_slot0_taken", 64'(pt[i]), 64'h1);
      chk("t3_slot1_ghr", 64'(pg[i][15:8]), 64'h01);
    end

    // A fetch-side speculative update and an EXE restore in the same cycle: the restore wins.
    tick(); clr_in();
    if_valid = 2'b11; if_hit = 2'b11; if_pc = {32'h204, 32'h200};
    ex_valid = 1'b1; ex_is_cond = 1'b1; ex_taken = 1'b0; ex_mispredict = 1'b1;
    ex_ghr = 8'hA5; ex_pc = 32'h600;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("t3_ghr_shift", 64'(pg[i][7:0]), 64'h03);

    tick(); clr_in();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("t4_restore_wins", 64'(pg[i][7:0]), 64'h4A);
      chk("t4_cnt_two", 64'(cnt[i]), 64'd2);
    end

    repeat (3) begin
      tick(); clr_in();
      ex_valid = 1'b1; ex_is_cond = 1'b1; ex_taken = 1'b0; ex_pc = 32'h408; ex_ghr = 8'h00;
    end
    repeat (4) begin
      tick(); clr_in();
      ex_valid = 1'b1; ex_is_cond = 1'b1; ex_taken = 1'b1; ex_pc = 32'h50C; ex_ghr = 8'h00;
    end
    tick(); clr_in();
    @(negedge clk);
    #1;
    chk("t5_model_sat_low", 64'(m_pht[0][hidx(0, 8'h00, 32'h408)]), 64'd0);
    chk("t5_model_sat_high", 64'(m_pht[1][hidx(1, 8'h00, 32'h50C)]), 64'd7);
    chk("t6_model_concat_idx", 64'(hidx(1, 8'hA5, 32'h60C)), 64'h53);

    repeat (1500) begin
      tick();
      rand_drive();
    end

    tick(); clr_in(); reset = 1'b1;
    tick(); reset = 1'b0;
    wait_ready("t6_run_reset", 1'b1);

    repeat (300) begin
      tick();
      rand_drive();
    end

    tick(); clr_in(); reset = 1'b1;
    tick(); reset = 1'b0;
    repeat (60) begin
      tick();
      rand_drive();
    end
    tick(); clr_in(); reset = 1'b1;
    tick(); reset = 1'b0;
    wait_ready("t6_init_reset", 1'b1);

    repeat (300) begin
      tick();
      rand_drive();
    end

    tick(); clr_in();
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
